// File: rtl/sseg_capture.sv
// Receive-side monitor for a scanned 4-digit seven-segment bus: settles each strobe and decodes it back to a nibble/dp per digit.
// Optional per-digit valid timeout is enabled with `define SSEG_CAPTURE_TIMEOUT_EN.
module sseg_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  valid,
  output logic        bad_seg,
  output logic        frame_done
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("sseg_capture: SETTLE_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state;
  logic [11:0]   sync1, s;   // {an, seg, dp}
  logic [CW-1:0] cnt;
  logic [3:0]    seen;

  logic          changed, new_onehot, cap, pat_ok;
  logic [3:0]    pat_val, hit, seen_nxt;
  logic [1:0]    idx;

`ifdef SSEG_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tmr [4];
`endif

  always_comb begin
    changed    = (sync1 != s);
    new_onehot = $onehot(~sync1[11:8]);
    cap        = (state == SETTLE) && !changed && (cnt == CNT_MAX);

    if (!s[8])       idx = 2'd0;
    else if (!s[9])  idx = 2'd1;
    else if (!s[10]) idx = 2'd2;
    else             idx = 2'd3;
    hit      = 4'b0001 << idx;
    seen_nxt = seen | hit;

    pat_ok  = 1'b1;
    pat_val = 4'h0;
    case (s[7:1])
      7'b1000000: pat_val = 4'h0;
      7'b1111001: pat_val = 4'h1;
      7'b0100100: pat_val = 4'h2;
      7'b0110000: pat_val = 4'h3;
      7'b0011001: pat_val = 4'h4;
      7'b0010010: pat_val = 4'h5;
      7'b0000010: pat_val = 4'h6;
      7'b1111000: pat_val = 4'h7;
      7'b0000000: pat_val = 4'h8;
      7'b0010000: pat_val = 4'h9;
      7'b0001000: pat_val = 4'hA;
      7'b0000011: pat_val = 4'hB;
      7'b1000110: pat_val = 4'hC;
      7'b0100001: pat_val = 4'hD;
      7'b0000110: pat_val = 4'hE;
      7'b0001110: pat_val = 4'hF;
      default:    pat_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= '1;
      s          <= '1;
      cnt        <= '0;
      seen       <= '0;
      digits     <= '0;
      dps        <= '0;
      valid      <= '0;
      bad_seg    <= 1'b0;
      frame_done <= 1'b0;
`ifdef SSEG_CAPTURE_TIMEOUT_EN
      for (int i = 0; i < 4; i++) tmr[i] <= '0;
`endif
    end else begin
      sync1      <= {an, seg, dp};
      s          <= sync1;
      bad_seg    <= 1'b0;
      frame_done <= 1'b0;

      if (changed)              cnt <= CW'(1);
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;

`ifdef SSEG_CAPTURE_TIMEOUT_EN
      // Placed before the capture so a same-cycle good capture overrides expiry.
      for (int i = 0; i < 4; i++) begin
        if (tmr[i] != TMAX)          tmr[i]   <= tmr[i] + 1'b1;
        if (tmr[i] == TMAX - 1'b1)   valid[i] <= 1'b0;
      end
      if (cap && pat_ok) tmr[idx] <= '0;
`endif

      case (state)
        IDLE:   if (changed && new_onehot) state <= SETTLE;
        SETTLE: begin
          if (changed) begin
            state <= new_onehot ? SETTLE : IDLE;
          end else if (cap) begin
            state <= HOLD;
            if (pat_ok) begin
              digits[{idx, 2'b00} +: 4] <= pat_val;
              dps[idx]                  <= ~s[0];
              valid[idx]                <= 1'b1;
              if (seen_nxt == 4'hF) begin
                frame_done <= 1'b1;
                seen       <= '0;
              end else begin
                seen       <= seen_nxt;
              end
            end else begin
              valid[idx] <= 1'b0;
              bad_seg    <= 1'b1;
            end
          end
        end
        HOLD:   if (changed) state <= new_onehot ? SETTLE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: a bench-side model queues expected captures per dwell,
// and a monitor compares them on the predicted cycle and flags any unexpected pulse.
module tb_sseg_capture;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dps, valid;
  logic        bad_seg, frame_done;

  sseg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
    .digits(digits), .dps(dps), .valid(valid), .bad_seg(bad_seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    int         dig;
    logic [3:0] val;
    logic       dpv;
    logic       good;
    logic       frame;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;

  logic [6:0]  glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [15:0] exp_digits;
  logic [3:0]  exp_dps, exp_valid, seen;
  logic [11:0] prev;

  // Scoreboard monitor: compare each queued capture on its cycle; no pulses elsewhere.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0 && q[0].at == cyc) begin
      mon_e = q.pop_front();
      checks += 3;
      if (bad_seg !== !mon_e.good) begin
        errors++; $display("FAIL cap_bad_seg cyc %0d dig %0d got %b want %b", cyc, mon_e.dig, bad_seg, !mon_e.good);
      end
      if (frame_done !== mon_e.frame) begin
        errors++; $display("FAIL cap_frame cyc %0d dig %0d got %b want %b", cyc, mon_e.dig, frame_done, mon_e.frame);
      end
      if (valid[mon_e.dig] !== mon_e.good) begin
        errors++; $display("FAIL cap_valid cyc %0d dig %0d got %b want %b", cyc, mon_e.dig, valid[mon_e.dig], mon_e.good);
      end
      if (mon_e.good) begin
        checks += 2;
        if (digits[mon_e.dig*4 +: 4] !== mon_e.val) begin
          errors++; $display("FAIL cap_nibble cyc %0d dig %0d got %h want %h", cyc, mon_e.dig, digits[mon_e.dig*4 +: 4], mon_e.val);
        end
        if (dps[mon_e.dig] !== mon_e.dpv) begin
          errors++; $display("FAIL cap_dp cyc %0d dig %0d got %b want %b", cyc, mon_e.dig, dps[mon_e.dig], mon_e.dpv);
        end
      end
    end else begin
      checks++;
      if (bad_seg !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL stray_pulse cyc %0d bad_seg %b frame_done %b want 0 0", cyc, bad_seg, frame_done);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_digits = '0; exp_dps = '0; exp_valid = '0; seen = '0; prev = 12'hFFF;
  endtask

  // Drive a vector and, if it forms a capturing dwell, queue the expected result.
  task automatic start_dwell(input logic [3:0] a, input logic [6:0] sg, input logic d, input int len);
    logic [11:0] v;
    ev_t         e;
    int          i;
    logic        good;
    logic [3:0]  nib;
    v = {a, sg, d};
    an = a; seg = sg; dp = d;
    if (v != prev && $onehot(~a) && len >= SETTLE + 1) begin
      i = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) i = k;
      good = 1'b0; nib = 4'h0;
      for (int k = 0; k < 16; k++) if (glyph[k] == sg) begin good = 1'b1; nib = 4'(k); end
      e.at = cyc + SETTLE + 2; e.dig = i; e.val = nib; e.dpv = ~d; e.good = good; e.frame = 1'b0;
      if (good) begin
        exp_digits[i*4 +: 4] = nib; exp_dps[i] = ~d; exp_valid[i] = 1'b1; seen[i] = 1'b1;
        if (seen == 4'hF) begin e.frame = 1'b1; seen = '0; end
      end else begin
        exp_valid[i] = 1'b0;
      end
      q.push_back(e);
    end
    prev = v;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] sg, input logic d, input int len);
    start_dwell(a, sg, d, len);
    step(len);
  endtask

  task automatic scan4(input logic [15:0] vals, input logic [3:0] dpon, input int len);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 4'hF; a[i] = 1'b0;
      dwell(a, glyph[vals[i*4 +: 4]], ~dpon[i], len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    step(3);
    checks += 3;
    if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", digits); end
    if (dps !== 4'b0000 || valid !== 4'b0000) begin
      errors++; $display("FAIL reset_flags dps %b valid %b want 0000 0000", dps, valid);
    end
    if (bad_seg !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses bad_seg %b frame_done %b want 0 0", bad_seg, frame_done);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_scan();
    start_dwell(4'b1110, glyph[1], 1'b1, 20);
    step(5);   // edge t0+4
    checks++;
    if (valid[0] !== 1'b0 || digits !== 16'h0000) begin
      errors++; $display("FAIL scan_early valid0 %b digits %h want 0 0000", valid[0], digits);
    end
    step(1);   // edge t0+5
    checks++;
    if (valid[0] !== 1'b1 || digits[3:0] !== 4'h1) begin
      errors++; $display("FAIL scan_latency valid0 %b nib %h want 1 1", valid[0], digits[3:0]);
    end
    step(14);
    dwell(4'b1101, glyph[2], 1'b1, 20);
    dwell(4'b1011, glyph[3], 1'b0, 20);
    dwell(4'b0111, glyph[4], 1'b1, 20);
    checks += 3;
    if (digits !== 16'h4321) begin errors++; $display("FAIL scan_digits got %h want 4321", digits); end
    if (dps !== 4'b0100)     begin errors++; $display("FAIL scan_dps got %b want 0100", dps); end
    if (valid !== 4'b1111)   begin errors++; $display("FAIL scan_valid got %b want 1111", valid); end
  endtask

  task automatic test_short_dwell();
    dwell(4'b1101, glyph[7], 1'b1, 3);
    dwell(4'b1111, 7'h7F, 1'b1, 10);
    checks++;
    if (digits !== exp_digits) begin
      errors++; $display("FAIL short_dwell digits got %h want %h", digits, exp_digits);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] gl;
    gl = glyph[5] ^ 7'b0000001;
    dwell(4'b1011, glyph[5], 1'b1, 2);
    dwell(4'b1011, gl, 1'b1, 1);
    start_dwell(4'b1011, glyph[5], 1'b1, 17);
    step(5);
    checks++;
    if (digits[11:8] !== 4'h3) begin
      errors++; $display("FAIL glitch_early nib2 got %h want 3", digits[11:8]);
    end
    step(1);
    checks++;
    if (digits[11:8] !== 4'h5 || dps[2] !== 1'b0) begin
      errors++; $display("FAIL glitch_capture nib2 %h dp2 %b want 5 0", digits[11:8], dps[2]);
    end
    step(11);
  endtask

  task automatic test_bad();
    dwell(4'b1110, 7'h7F, 1'b1, 20);
    checks++;
    if (valid[0] !== 1'b0 || digits[3:0] !== 4'h1) begin
      errors++; $display("FAIL bad_hold valid0 %b nib0 %h want 0 1", valid[0], digits[3:0]);
    end
    dwell(4'b1110, glyph[10], 1'b1, 20);
    checks++;
    if (valid[0] !== 1'b1 || digits[3:0] !== 4'hA) begin
      errors++; $display("FAIL bad_recover valid0 %b nib0 %h want 1 a", valid[0], digits[3:0]);
    end
  endtask

  task automatic test_ghost();
    dwell(4'b1100, glyph[8], 1'b1, 50);
    dwell(4'b1111, glyph[8], 1'b1, 50);
    checks += 2;
    if (digits !== exp_digits) begin errors++; $display("FAIL ghost_digits got %h want %h", digits, exp_digits); end
    if (dps !== exp_dps)       begin errors++; $display("FAIL ghost_dps got %b want %b", dps, exp_dps); end
`ifndef SSEG_CAPTURE_TIMEOUT_EN
    checks++;
    if (valid !== exp_valid)   begin errors++; $display("FAIL ghost_valid got %b want %b", valid, exp_valid); end
`endif
  endtask

  task automatic test_timeout();
    int         c3;
    logic       want3;
    logic [3:0] a;
`ifdef SSEG_CAPTURE_TIMEOUT_EN
    want3 = 1'b0;
`else
    want3 = 1'b1;
`endif
    dwell(4'b1110, glyph[9], 1'b1, 20);
    dwell(4'b1101, glyph[8], 1'b1, 20);
    dwell(4'b1011, glyph[7], 1'b1, 20);
    start_dwell(4'b0111, glyph[6], 1'b1, 20);
    c3 = q[$].at;
    step(20);
    for (int r = 0; r < 9; r++) begin
      a = 4'hF; a[r % 3] = 1'b0;
      start_dwell(a, glyph[r], 1'b1, 20);
      for (int j = 0; j < 20; j++) begin
        step(1);
        if (cyc == c3 + 99) begin
          checks++;
          if (valid[3] !== 1'b1) begin errors++; $display("FAIL timeout_early valid3 got %b want 1", valid[3]); end
        end
        if (cyc == c3 + 100) begin
          checks += 2;
          if (valid[3] !== want3) begin errors++; $display("FAIL timeout_edge valid3 got %b want %b", valid[3], want3); end
          if (valid[2:0] !== 3'b111) begin errors++; $display("FAIL timeout_others valid got %b want 111", valid[2:0]); end
        end
      end
    end
    exp_valid[3] = want3;
  endtask

  task automatic test_reset_mid();
    scan4(16'hC0DE, 4'b0000, 20);
    an = 4'b1110; seg = glyph[8]; dp = 1'b1;
    prev = {an, seg, dp};
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks += 3;
    if (digits !== 16'h0000) begin errors++; $display("FAIL midrst_digits got %h want 0000", digits); end
    if (dps !== 4'b0000 || valid !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags dps %b valid %b want 0000 0000", dps, valid);
    end
    if (bad_seg !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses bad_seg %b frame_done %b want 0 0", bad_seg, frame_done);
    end
    model_reset();
    start_dwell(4'b1110, glyph[8], 1'b1, 20);
    step(5);
    checks++;
    if (valid !== 4'b0000) begin errors++; $display("FAIL midrst_early valid got %b want 0000", valid); end
    step(15);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_short_dwell();
    test_glitch();
    test_bad();
    test_ghost();
    test_timeout();
    test_reset_mid();
    dwell(4'b1111, 7'h7F, 1'b1, SETTLE + 4);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
